// File: rtl/cv32e40p_apu_arbiter_if.sv
// APU bundle between the cv32e40p cores, the shared-FPU arbiter and the FPU wrapper.
// Core-side fields are packed per core, with core 0 at the LSBs.
interface cv32e40p_apu_arbiter_if #(
    parameter int NUM_CORES    = 2,
    parameter int APU_NARGS    = 3,
    parameter int APU_WOP      = 6,
    parameter int APU_NDSFLAGS = 15,
    parameter int APU_NUSFLAGS = 5
);
    logic [NUM_CORES-1:0]              core_req_i;
    logic [NUM_CORES-1:0]              core_gnt_o;
    logic [NUM_CORES*APU_NARGS*32-1:0] core_operands_i;
    logic [NUM_CORES*APU_WOP-1:0]      core_op_i;
    logic [NUM_CORES*APU_NDSFLAGS-1:0] core_flags_i;
    logic [NUM_CORES-1:0]              core_rvalid_o;
    logic [31:0]                       core_rdata_o;
    logic [APU_NUSFLAGS-1:0]           core_rflags_o;

    logic                              fpu_req_o;
    logic                              fpu_gnt_i;
    logic [APU_NARGS*32-1:0]           fpu_operands_o;
    logic [APU_WOP-1:0]                fpu_op_o;
    logic [APU_NDSFLAGS-1:0]           fpu_flags_o;
    logic                              fpu_rvalid_i;
    logic [31:0]                       fpu_rdata_i;
    logic [APU_NUSFLAGS-1:0]           fpu_rflags_i;

    modport slave (
        input  core_req_i, core_operands_i, core_op_i, core_flags_i,
        input  fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
        output fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o
    );

    modport master (
        output core_req_i, core_operands_i, core_op_i, core_flags_i,
        output fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
        input  fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o
    );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin sharing of one FPU wrapper between NUM_CORES cores.
// An in-order ID FIFO steers each FPU result back to the core that issued it.
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES       = 2,
    parameter int APU_NARGS       = 3,
    parameter int APU_WOP         = 6,
    parameter int APU_NDSFLAGS    = 15,
    parameter int APU_NUSFLAGS    = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    cv32e40p_apu_arbiter_if.slave              apu,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);
    localparam int IDW = $clog2(NUM_CORES);
    localparam int AW  = $clog2(MAX_OUTSTANDING);
    localparam int OPW = APU_NARGS * 32;

    logic [IDW-1:0]          rr_ptr;
    logic [IDW-1:0]          win_id;
    logic [IDW-1:0]          head_id;
    logic                    any_req;
    logic                    full;
    logic                    empty;
    logic                    accept;
    logic                    pop;

    logic [IDW-1:0]          id_mem [MAX_OUTSTANDING];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;

    logic [NUM_CORES-1:0]    gnt;
    logic [NUM_CORES-1:0]    rvalid;
    logic [OPW-1:0]          sel_operands;
    logic [APU_WOP-1:0]      sel_op;
    logic [APU_NDSFLAGS-1:0] sel_flags;

    // Scan downward so the lowest offset from rr_ptr is the last hit.
    always_comb begin
        int idx;
        logic [IDW-1:0] idx_id;
        win_id  = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_id  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            idx_id = idx[IDW-1:0];
            if (apu.core_req_i[idx_id]) begin
                win_id  = idx_id;
                any_req = 1'b1;
            end
        end
    end

    assign full    = (count == (AW+1)'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign accept  = any_req & ~full & apu.fpu_gnt_i;
    assign pop     = apu.fpu_rvalid_i & ~empty;
    assign head_id = id_mem[rd_ptr];

    always_comb begin
        sel_operands = '0;
        sel_op       = '0;
        sel_flags    = '0;
        gnt          = '0;
        rvalid       = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (any_req && win_id == IDW'(j)) begin
                sel_operands = apu.core_operands_i[j*OPW +: OPW];
                sel_op       = apu.core_op_i[j*APU_WOP +: APU_WOP];
                sel_flags    = apu.core_flags_i[j*APU_NDSFLAGS +: APU_NDSFLAGS];
            end
            gnt[j]    = accept && (win_id == IDW'(j));
            rvalid[j] = pop && (head_id == IDW'(j));
        end
    end

    assign apu.fpu_req_o      = any_req & ~full;
    assign apu.fpu_operands_o = sel_operands;
    assign apu.fpu_op_o       = sel_op;
    assign apu.fpu_flags_o    = sel_flags;
    assign apu.core_gnt_o     = gnt;
    assign apu.core_rvalid_o  = rvalid;
    assign apu.core_rdata_o   = apu.fpu_rdata_i;
    assign apu.core_rflags_o  = apu.fpu_rflags_i;
    assign outstanding_o      = count;

    // ID storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_mem[wr_ptr] <= win_id;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (win_id == IDW'(NUM_CORES - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= win_id + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (apu.fpu_rvalid_i && empty) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cv32e40p_apu_arbiter.md
Name: cv32e40p_apu_arbiter

Overview:
- Shares one FPU wrapper (APU interface) between NUM_CORES cv32e40p cores in a cluster configuration.
- Round-robin arbitration of core APU requests onto the single FPU request port.
- Records the granted core ID in an in-order ID FIFO and steers each FPU result back to its issuing core.
- Sits between the cores' apu_* ports and the FPU wrapper, replacing the 1:1 core-to-FPU hookup.

Parameters:
NUM_CORES, 2, number of requesting cores (2..8)
APU_NARGS, 3, operands per request
APU_WOP, 6, operation field width
APU_NDSFLAGS, 15, downstream flag width
APU_NUSFLAGS, 5, upstream (result) flag width
MAX_OUTSTANDING, 4, ID FIFO depth (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
core_req_i  in  NUM_CORES  per-core APU request
core_gnt_o  out  NUM_CORES  per-core APU grant
core_operands_i  in  NUM_CORES*APU_NARGS*32  packed operands, core 0 at LSBs
core_op_i  in  NUM_CORES*APU_WOP  packed op codes
core_flags_i  in  NUM_CORES*APU_NDSFLAGS  packed downstream flags
core_rvalid_o  out  NUM_CORES  per-core result valid
core_rdata_o  out  32  result data, broadcast to all cores
core_rflags_o  out  APU_NUSFLAGS  result flags, broadcast
fpu_req_o  out  1  request to FPU
fpu_gnt_i  in  1  FPU grant
fpu_operands_o  out  APU_NARGS*32  operands of winning core
fpu_op_o  out  APU_WOP  op of winning core
fpu_flags_o  out  APU_NDSFLAGS  flags of winning core
fpu_rvalid_i  in  1  FPU result valid
fpu_rdata_i  in  32  FPU result
fpu_rflags_i  in  APU_NUSFLAGS  FPU result flags
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  issued, unanswered operations
err_o  out  1  sticky: result received with empty ID FIFO

Behaviour:
- Reset (rst_i asynchronous): RR pointer=0, FIFO empty, outstanding_o=0, err_o=0. All combinational outputs are 0 when no core requests.
- Arbitration (combinational):
  - Winner = first requesting core at or after the RR pointer, searching upward with wrap.
  - fpu_req_o = any core_req_i & !full.
  - fpu_operands_o / fpu_op_o / fpu_flags_o = winner's fields; all zero if no request.
- Grant: core_gnt_o[winner] = fpu_req_o & fpu_gnt_i. At most one grant bit set per cycle.
- Handshake:
  - Accepted = fpu_req_o & fpu_gnt_i.
  - On accept: push winner ID into the FIFO and set RR pointer = (winner+1) mod NUM_CORES.
  - With no accept, the pointer holds. A requesting core is never bypassed more than NUM_CORES-1 times.
- Full: when the FIFO holds MAX_OUTSTANDING entries, fpu_req_o=0 and no grants are issued, even if a pop occurs the same cycle. Issue resumes the cycle after the count drops.
- Response path, zero added latency:
  - core_rvalid_o[head ID] = fpu_rvalid_i when the FIFO is non-empty; pop on fpu_rvalid_i.
  - core_rdata_o / core_rflags_o pass through fpu_rdata_i / fpu_rflags_i unconditionally.
  - The FPU returns results in issue order; the arbiter does not reorder.
- Empty: fpu_rvalid_i with an empty FIFO sets err_o (cleared only by reset). No core_rvalid_o is asserted and no pop occurs.
- Simultaneous push and pop (not full): count unchanged, head advances, new ID written at tail. Pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o = FIFO count, updated one cycle after the push/pop.
- Requests are not retracted: a core holds req and its fields stable until granted. The arbiter may change winner only on an accept cycle.
- Reset mid-operation: in-flight FIFO entries are discarded. Results arriving after reset set err_o.

Test Plan:
- Single core: core 1 req with op=0x05, fpu_gnt_i=1 -> core_gnt_o=2'b10, fpu_op_o=0x05, outstanding_o 0->1. fpu_rvalid_i with rdata=0x3F800000 next cycle -> core_rvalid_o=2'b10, core_rdata_o=0x3F800000, outstanding_o->0.
- Fairness: both cores req continuously, fpu_gnt_i=1, results returned 2 cycles later -> grants alternate 0,1,0,1. Each result routed to its issuing core in order.
- Full: MAX_OUTSTANDING=4, four accepts with no results -> fpu_req_o=0 and core_gnt_o=0 while outstanding_o=4. One fpu_rvalid_i -> request re-asserted the following cycle.
- FPU back-pressure: fpu_gnt_i=0 for 3 cycles with core 0 requesting -> fpu_req_o=1 throughout, no grant, pointer unchanged, outstanding_o=0.
- Spurious result: fpu_rvalid_i with FIFO empty -> core_rvalid_o=0, err_o=1 and it stays 1 until rst_i.
- Async reset with 2 outstanding: assert rst_i mid-cycle -> outstanding_o=0 and err_o=0 immediately. Next grant goes to core 0 when both request.
